// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: mdop encodings,
// latencies, FSM state encodings and small decode helpers.
// Optional feature macro: MDU_DIV_EN (enables DIV/DIVU; otherwise they act as NONE).
package mdu_sched_pkg;

  typedef enum logic [2:0] {
    MDOP_NONE  = 3'd0,
    MDOP_MULT  = 3'd1,
    MDOP_MULTU = 3'd2,
    MDOP_DIV   = 3'd3,
    MDOP_DIVU  = 3'd4,
    MDOP_MTHI  = 3'd5,
    MDOP_MTLO  = 3'd6
  } mdop_e;

  localparam int MDU_MULT_LAT = 5;
  localparam int MDU_DIV_LAT  = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU);
  endfunction

  // Division only counts as a real operation when the divider is built in.
  function automatic logic is_div(input logic [2:0] op);
    return ((op == MDOP_DIV) || (op == MDOP_DIVU)) && DIV_EN;
  endfunction

  function automatic logic is_long(input logic [2:0] op);
    return is_mul(op) || is_div(op);
  endfunction

  // Counter preload: the RUN state lasts exactly latency cycles.
  function automatic logic [3:0] lat_m1(input logic [2:0] op);
    return is_div(op) ? 4'(MDU_DIV_LAT - 1) : 4'(MDU_MULT_LAT - 1);
  endfunction

endpackage

// File: rtl/mdu_sched_if.sv
// Pipeline-side interface of the multiply/divide scheduler.
// Handshake: the E stage asserts start with mdop/a/b for one cycle; the op is
// accepted only while busy=0. busy=1 means a long op is in flight and any start
// is ignored. stall is combinational and tells the pipeline to freeze D and
// bubble E while a D-stage MD instruction would collide with a running op.
interface mdu_sched_if;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hi;
  logic        d_use_md;
  logic        busy;
  logic        stall;
  logic [31:0] out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [0:0]  dbg_state;

  modport master (
    output start, mdop, a, b, rd_hi, d_use_md,
    input  busy, stall, out, hi, lo, dbg_state
  );

  modport slave (
    input  start, mdop, a, b, rd_hi, d_use_md,
    output busy, stall, out, hi, lo, dbg_state
  );
endinterface

// File: rtl/mdu_core.sv
// Combinational multiply/divide datapath. Division by zero yields zeros here;
// the scheduler suppresses the commit in that case.
// Optional feature macro: MDU_DIV_EN (builds the divider).
module mdu_core
  import mdu_sched_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  mdop,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
`ifdef MDU_DIV_EN
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
`endif

  // Select the result for the requested operation.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    prod_s = 64'($signed(a)) * 64'($signed(b));
    prod_u = {32'd0, a} * {32'd0, b};
`ifdef MDU_DIV_EN
    quo_s  = 32'sd0;
    rem_s  = 32'sd0;
`endif
    case (mdop)
      MDOP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MDOP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
`ifdef MDU_DIV_EN
      MDOP_DIV: begin
        if (b != 32'd0) begin
          quo_s  = $signed(a) / $signed(b);
          rem_s  = $signed(a) % $signed(b);
          res_lo = quo_s;
          res_hi = rem_s;
        end
      end
      MDOP_DIVU: begin
        if (b != 32'd0) begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
`endif
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: launches long ops from the E stage, holds the
// result privately for the op latency, then commits it to HI/LO.
// Optional feature macro: MDU_DIV_EN (DIV/DIVU take 10 cycles; otherwise no-ops).
module mdu_sched
  import mdu_sched_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mdu_sched_if.slave mdu
);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        commit_en;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] core_hi;
  logic [31:0] core_lo;
  logic        busy;
  logic        launch;
  logic        finish;

  mdu_core u_core (
    .a      (mdu.a),
    .b      (mdu.b),
    .mdop   (mdu.mdop),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  assign busy   = (state == ST_RUN);
  assign launch = (state == ST_IDLE) && mdu.start && is_long(mdu.mdop);
  assign finish = (state == ST_RUN) && (cnt == 4'd0);

  // FSM, latency counter and private result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      res_hi    <= 32'd0;
      res_lo    <= 32'd0;
      commit_en <= 1'b0;
    end else if (launch) begin
      state     <= ST_RUN;
      cnt       <= lat_m1(mdu.mdop);
      res_hi    <= core_hi;
      res_lo    <= core_lo;
      // A divide by zero still runs its full latency but leaves HI/LO alone.
      commit_en <= !(is_div(mdu.mdop) && (mdu.b == 32'd0));
    end else if (finish) begin
      state     <= ST_IDLE;
    end else if (state == ST_RUN) begin
      cnt       <= cnt - 4'd1;
    end
  end

  // Architectural HI/LO: commit at the end of RUN, or direct move-to writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (finish) begin
      if (commit_en) begin
        hi_r <= res_hi;
        lo_r <= res_lo;
      end
    end else if ((state == ST_IDLE) && mdu.start) begin
      if (mdu.mdop == MDOP_MTHI) hi_r <= mdu.a;
      if (mdu.mdop == MDOP_MTLO) lo_r <= mdu.a;
    end
  end

  assign mdu.busy      = busy;
  assign mdu.stall     = !reset && mdu.d_use_md && (busy || (mdu.start && is_long(mdu.mdop)));
  assign mdu.out       = mdu.rd_hi ? hi_r : lo_r;
  assign mdu.hi        = hi_r;
  assign mdu.lo        = lo_r;
  assign mdu.dbg_state = state;

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed MD ops, random multiplies,
// stall behaviour, ignored start during RUN and reset in mid-operation.
module tb_mdu_sched;
  import mdu_sched_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_sched_if mdu ();

  mdu_sched dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  int total = 0;
  int bad = 0;
  int ign_cnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  // Flag any start presented while a long op is running.
  always @(negedge clk) begin
    if (!reset && mdu.start && mdu.busy) begin
      ign_cnt++;
      $display("note: start while busy at %0t (ignored by design)", $time);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mdu.start = 1'b0;
    mdu.mdop  = MDOP_NONE;
  endtask

  // Launch a long op in the current cycle, count busy cycles, then check commit.
  task automatic op_long(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                         input bit inject);
    int n;
    logic [63:0] e;
    exp_q.push_back({ehi, elo});
    mdu.start = 1'b1;
    mdu.mdop  = op;
    mdu.a     = av;
    mdu.b     = bv;
    #1;
    check_val("busy_at_start", 64'(mdu.busy), 64'd0);
    if (mdu.d_use_md) check_val("stall_at_start", 64'(mdu.stall), 64'(lat > 0));
    next_cycle();
    idle_inputs();
    n = 0;
    while (mdu.busy && n < 40) begin
      n++;
      if (mdu.d_use_md) check_val("stall_run", 64'(mdu.stall), 64'd1);
      check_val("hold_hi", 64'(mdu.hi), 64'(hi_m));
      check_val("hold_lo", 64'(mdu.lo), 64'(lo_m));
      if (inject && n == 2) begin
        mdu.start = 1'b1;
        mdu.mdop  = MDOP_MULT;
        mdu.a     = 32'd7;
        mdu.b     = 32'd9;
      end
      next_cycle();
      idle_inputs();
    end
    check_val("latency", 64'(n), 64'(lat));
    if (mdu.d_use_md) check_val("stall_after", 64'(mdu.stall), 64'd0);
    e = exp_q.pop_front();
    check_val("hi", 64'(mdu.hi), 64'(e[63:32]));
    check_val("lo", 64'(mdu.lo), 64'(e[31:0]));
    mdu.rd_hi = 1'b1;
    #1;
    check_val("out_hi", 64'(mdu.out), 64'(e[63:32]));
    mdu.rd_hi = 1'b0;
    #1;
    check_val("out_lo", 64'(mdu.out), 64'(e[31:0]));
    hi_m = e[63:32];
    lo_m = e[31:0];
  endtask

  // Move-to HI/LO: written on the next edge, never busy.
  task automatic mt_op(input logic [2:0] op, input logic [31:0] av);
    logic [63:0] e;
    if (op == MDOP_MTHI) exp_q.push_back({av, lo_m});
    else                 exp_q.push_back({hi_m, av});
    mdu.start = 1'b1;
    mdu.mdop  = op;
    mdu.a     = av;
    #1;
    check_val("mt_busy0", 64'(mdu.busy), 64'd0);
    check_val("mt_stall0", 64'(mdu.stall), 64'd0);
    next_cycle();
    idle_inputs();
    check_val("mt_busy1", 64'(mdu.busy), 64'd0);
    mdu.rd_hi = (op == MDOP_MTHI);
    #1;
    e = exp_q.pop_front();
    check_val("mt_out", 64'(mdu.out), (op == MDOP_MTHI) ? 64'(e[63:32]) : 64'(e[31:0]));
    check_val("mt_hi", 64'(mdu.hi), 64'(e[63:32]));
    check_val("mt_lo", 64'(mdu.lo), 64'(e[31:0]));
    mdu.rd_hi = 1'b0;
    hi_m = e[63:32];
    lo_m = e[31:0];
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] p;
    logic [2:0]  rop;
    int dl;
    dl = DIV_ON ? MDU_DIV_LAT : 0;

    // Reset: outputs cleared, stall forced low even with a request pending.
    reset        = 1'b1;
    mdu.start    = 1'b1;
    mdu.mdop     = MDOP_MULT;
    mdu.a        = 32'd3;
    mdu.b        = 32'd4;
    mdu.rd_hi    = 1'b0;
    mdu.d_use_md = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", 64'(mdu.busy), 64'd0);
    check_val("rst_stall", 64'(mdu.stall), 64'd0);
    check_val("rst_hi", 64'(mdu.hi), 64'd0);
    check_val("rst_lo", 64'(mdu.lo), 64'd0);
    check_val("rst_out", 64'(mdu.out), 64'd0);
    check_val("rst_state", 64'(mdu.dbg_state), 64'(ST_IDLE));
    idle_inputs();
    mdu.d_use_md = 1'b0;
    reset = 1'b0;
    next_cycle();

    // Directed arithmetic, issued back to back.
    op_long(MDOP_MULT,  32'hFFFFFFFE, 32'd3, MDU_MULT_LAT, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    op_long(MDOP_MULTU, 32'hFFFFFFFF, 32'd2, MDU_MULT_LAT, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    if (DIV_ON) op_long(MDOP_DIV, 32'hFFFFFFF9, 32'd2, dl, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    else        op_long(MDOP_DIV, 32'hFFFFFFF9, 32'd2, dl, hi_m, lo_m, 1'b0);
    op_long(MDOP_DIV, 32'd55, 32'd0, dl, hi_m, lo_m, 1'b0);
    if (DIV_ON) op_long(MDOP_DIVU, 32'd100, 32'd7, dl, 32'd2, 32'd14, 1'b0);
    else        op_long(MDOP_DIVU, 32'd100, 32'd7, dl, hi_m, lo_m, 1'b0);

    // Move-to ops and mfhi/mflo readback.
    mdu.d_use_md = 1'b1;
    mt_op(MDOP_MTHI, 32'h12345678);
    mt_op(MDOP_MTLO, 32'hCAFEF00D);

    // start with NONE does nothing.
    mdu.start = 1'b1;
    mdu.mdop  = MDOP_NONE;
    mdu.a     = 32'hDEADBEEF;
    #1;
    check_val("none_stall", 64'(mdu.stall), 64'd0);
    next_cycle();
    idle_inputs();
    check_val("none_busy", 64'(mdu.busy), 64'd0);
    check_val("none_hi", 64'(mdu.hi), 64'(hi_m));
    check_val("none_lo", 64'(mdu.lo), 64'(lo_m));

    // Stall window with D-stage MD op, plus a second start during RUN.
    op_long(MDOP_MULT, 32'd6, 32'd7, MDU_MULT_LAT, 32'd0, 32'd42, 1'b1);
    check_val("ignored_starts", 64'(ign_cnt), 64'd1);
    mdu.d_use_md = 1'b0;

    // Random multiplies against a sign-extension model.
    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = ($urandom_range(0, 1) == 0) ? MDOP_MULT : MDOP_MULTU;
      if (rop == MDOP_MULT) p = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
      else                  p = {32'd0, ra} * {32'd0, rb};
      op_long(rop, ra, rb, MDU_MULT_LAT, p[63:32], p[31:0], 1'b0);
    end

    // Reset in the third cycle of a long op: result must be dropped.
    mdu.start = 1'b1;
    mdu.mdop  = DIV_ON ? MDOP_DIV : MDOP_MULT;
    mdu.a     = 32'd100;
    mdu.b     = 32'd3;
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    #1;
    reset = 1'b1;
    mdu.start    = 1'b1;
    mdu.mdop     = MDOP_MULT;
    mdu.d_use_md = 1'b1;
    #1;
    check_val("midrst_busy", 64'(mdu.busy), 64'd0);
    check_val("midrst_stall", 64'(mdu.stall), 64'd0);
    check_val("midrst_hi", 64'(mdu.hi), 64'd0);
    check_val("midrst_lo", 64'(mdu.lo), 64'd0);
    check_val("midrst_state", 64'(mdu.dbg_state), 64'(ST_IDLE));
    next_cycle();
    idle_inputs();
    mdu.d_use_md = 1'b0;
    reset = 1'b0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    repeat (15) next_cycle();
    check_val("postrst_busy", 64'(mdu.busy), 64'd0);
    check_val("postrst_hi", 64'(mdu.hi), 64'(hi_m));
    check_val("postrst_lo", 64'(mdu.lo), 64'(lo_m));
    check_val("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
MDU_SCHED -- requirements
Module: mdu_sched

Interface
REQ-001 The block SHALL have ports clk (input, 1, sole clock) and reset (input, 1, asynchronous, active-high).
REQ-002 The block SHALL have port start (input, 1): E-stage instruction is a multiply/divide/move-to op, valid this cycle.
REQ-003 The block SHALL have port mdop (input, 3): operation code NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO.
REQ-004 The block SHALL have ports a and b (input, 32 each): forwarded rs and rt values from E stage.
REQ-005 The block SHALL have port rd_hi (input, 1): 1 selects HI and 0 selects LO for out.
REQ-006 The block SHALL have port d_use_md (input, 1): D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-007 The block SHALL have port busy (output, 1): long operation in progress.
REQ-008 The block SHALL have port stall (output, 1): freeze D stage and bubble E.
REQ-009 The block SHALL have port out (output, 32): selected HI/LO value for mfhi/mflo.
REQ-010 The block SHALL have ports hi and lo (output, 32 each): architectural registers, debug view.

Function
REQ-011 The block SHALL implement states IDLE and RUN, with a 4-bit down-counter cnt and result holding registers res_hi and res_lo.
REQ-012 IDLE with start=1 and mdop in {MULT, MULTU, DIV, DIVU} SHALL sample a and b, compute into res_hi/res_lo, load cnt with latency-1, and enter RUN on the same edge.
REQ-013 Latency SHALL be 5 cycles for MULT/MULTU and 10 cycles for DIV/DIVU: busy=1 for exactly cycles t+1..t+N after start in cycle t.
REQ-014 HI and LO SHALL update on the edge ending cycle t+N; out reflects the new value from cycle t+N+1; RUN returns to IDLE on that same edge.
REQ-015 MULT SHALL produce the signed 64-bit product and MULTU the unsigned product, with HI = [63:32] and LO = [31:0].
REQ-016 DIV SHALL produce a signed quotient in LO and signed remainder in HI (remainder takes the sign of the dividend); DIVU SHALL produce unsigned results.
REQ-017 Division with b=0 SHALL still occupy 10 busy cycles and SHALL leave HI and LO unchanged.
REQ-018 MTHI/MTLO with start=1 in IDLE SHALL write a into HI/LO on the next edge, with no busy cycle.
REQ-019 stall SHALL equal d_use_md & (busy | (start & mdop in {MULT, MULTU, DIV, DIVU})), and SHALL be combinational.
REQ-020 start=1 while in RUN SHALL be ignored with no state change; a bench assertion SHALL flag it.
REQ-021 start=1 with mdop=NONE SHALL be a no-op.
REQ-022 out SHALL be combinational from the HI/LO registers and rd_hi; it SHALL never show res_* before commit.
REQ-023 busy falling and a new start SHALL be legal in the same cycle t+N+1.

Reset
REQ-024 Asserting reset at any time, including mid-RUN, SHALL force state IDLE, cnt=0, busy=0, HI=LO=0, and res_hi=res_lo=0; the pending result SHALL be discarded.
REQ-025 With reset asserted, stall SHALL equal 0.

Configuration
REQ-026 With macro MDU_DIV_EN defined, DIV/DIVU SHALL behave per REQ-013/016/017.
REQ-027 Without MDU_DIV_EN, DIV/DIVU SHALL be treated as NONE: no busy, no stall contribution, and HI/LO unchanged.

Structure
REQ-028 The shared definitions header SHALL hold the mdop encodings, the latency constants MDU_MULT_LAT=5 and MDU_DIV_LAT=10, and the state encodings.
REQ-029 The arithmetic SHALL live in one combinational sub-module mdu_core (inputs a, b, mdop; outputs res_hi, res_lo), instantiated by mdu_sched.

Verification
REQ-030 MULT a=0xFFFFFFFE, b=3 SHALL give busy for exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-031 MULTU a=0xFFFFFFFF, b=2 SHALL give HI=0x00000001 and LO=0xFFFFFFFE.
REQ-032 DIV a=-7, b=2 SHALL give 10 busy cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIV with b=0 SHALL leave HI/LO at their prior values.
REQ-033 MTHI a=0x12345678, then mfhi read (rd_hi=1) the next cycle, SHALL give out=0x12345678 and busy=0 throughout.
REQ-034 MULT start with d_use_md=1 held SHALL give stall=1 in cycles t..t+5 and stall=0 at t+6; a second start during RUN SHALL leave the result unaffected.
REQ-035 Reset pulsed in cycle 3 of a DIV SHALL give busy=0, HI=LO=0, and no later commit.
